// File: rtl/serial_pkg.sv
// Shared defaults and helpers for the serial datapath blocks.
// Bundled with the pattern detector and its saturating counter.
package serial_pkg;

    localparam int               SERIAL_WIDTH_DEFAULT       = 4;
    localparam logic [3:0]       SERIAL_PATTERN_DEFAULT     = 4'b1011;
    localparam int               SERIAL_COUNT_WIDTH_DEFAULT = 8;

    // Bits needed to count sampled bits from 0 up to and including width.
    function automatic int fill_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : serial_pkg

// File: rtl/serial_pattern_detector_sat_counter.sv
// Saturating event counter with a sticky saturation flag.
// Reset and clear both return it to zero; reset takes priority.
module sat_counter #(
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   inc,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   sat
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;
    logic                   sat_q;
    logic                   sat_d;

    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (inc && (count_q != COUNT_MAX)) begin
            count_d = count_q + 1'b1;
            // The flag rises on the same edge the count reaches all-ones.
            if (count_d == COUNT_MAX) begin
                sat_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count = count_q;
    assign sat   = sat_q;

endmodule : sat_counter

// File: rtl/serial_pattern_detector.sv
// Detects a WIDTH-bit pattern in a gated serial stream, overlaps allowed.
// Every output is registered; match pulses one cycle after the completing bit.
module serial_pattern_detector
    import serial_pkg::*;
#(
    parameter int               WIDTH       = SERIAL_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] PATTERN     = WIDTH'(SERIAL_PATTERN_DEFAULT),
    parameter int               COUNT_WIDTH = SERIAL_COUNT_WIDTH_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   bit_in,
    input  logic                   bit_valid,
    input  logic                   clear,
    output logic                   match,
    output logic [COUNT_WIDTH-1:0] match_count,
    output logic                   count_sat,
    output logic [WIDTH-1:0]       history
);

    localparam int               FILL_W   = fill_width(WIDTH);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIDTH);
    localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(WIDTH - 1);

    // Qualifier: bit_in is consumed on exactly those rising edges where
    // bit_valid=1 and neither reset_n=0 nor clear=1; there is no back-pressure,
    // and bits presented with bit_valid=0 are ignored without affecting state.
    logic [WIDTH-1:0]  history_q;
    logic [WIDTH-1:0]  history_d;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    logic              match_q;
    logic              match_d;
    logic [WIDTH-1:0]  shifted;
    logic              hit;

    always_comb begin
        shifted   = {history_q[WIDTH-2:0], bit_in};
        // The fill guard keeps power-up zeros from matching an all-zero pattern.
        hit       = bit_valid && (fill_q >= FILL_ARM) && (shifted == PATTERN);
        history_d = history_q;
        fill_d    = fill_q;
        match_d   = 1'b0;
        if (bit_valid) begin
            history_d = shifted;
            match_d   = hit;
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            history_q <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
        end else begin
            history_q <= history_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
        end
    end

    sat_counter #(
        .COUNT_WIDTH(COUNT_WIDTH)
    ) u_match_counter (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (clear),
        .inc    (hit),
        .count  (match_count),
        .sat    (count_sat)
    );

    assign match   = match_q;
    assign history = history_q;

endmodule : serial_pattern_detector

// File: tb/tb_serial_pattern_detector.sv
// Scoreboard bench: three detector instances share one stimulus stream and
// are checked every cycle against a sequence-level reference model.
module tb_serial_pattern_detector;

  localparam int W = 14;  // {match, count[7:0], sat, history[3:0]}

  logic       clock;
  logic       reset_n;
  logic       bit_in;
  logic       bit_valid;
  logic       clear;

  logic       match_0, match_1, match_2;
  logic [7:0] count_0, count_1;
  logic [1:0] count_2;
  logic       sat_0, sat_1, sat_2;
  logic [3:0] hist_0, hist_1, hist_2;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q2[$];

  int n_cmp;
  int n_bad;
  int cycle;

  // reference model state: bits sampled since reset/clear (newest last)
  bit seen[$];
  int cnt[3];
  int pat[3];
  int maxc[3];

  serial_pattern_detector dut (
    .clock(clock), .reset_n(reset_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .clear(clear), .match(match_0), .match_count(count_0), .count_sat(sat_0),
    .history(hist_0)
  );

  serial_pattern_detector #(.WIDTH(4), .PATTERN(4'b0000), .COUNT_WIDTH(8)) dut_zero (
    .clock(clock), .reset_n(reset_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .clear(clear), .match(match_1), .match_count(count_1), .count_sat(sat_1),
    .history(hist_1)
  );

  serial_pattern_detector #(.WIDTH(4), .PATTERN(4'b1111), .COUNT_WIDTH(2)) dut_sat (
    .clock(clock), .reset_n(reset_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .clear(clear), .match(match_2), .match_count(count_2), .count_sat(sat_2),
    .history(hist_2)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    reset_n   = 1'b0;
    clear     = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  end

  always @(posedge clock) cycle <= cycle + 1;

  // reference model: one step per clock edge, pushes expected outputs
  task automatic model_step(input bit r, input bit c, input bit v, input bit b);
    int hv;
    bit m;
    logic [W-1:0] e;
    hv = 0;
    m  = 1'b0;
    if (!r || c) begin
      seen.delete();
      for (int i = 0; i < 3; i++) cnt[i] = 0;
    end else if (v) begin
      seen.push_back(b);
      if (seen.size() > 4) void'(seen.pop_front());
    end
    for (int k = 0; k < seen.size(); k++) hv = hv * 2 + int'(seen[k]);
    for (int i = 0; i < 3; i++) begin
      m = r && !c && v && (seen.size() == 4) && (hv == pat[i]);
      if (m && cnt[i] < maxc[i]) cnt[i] = cnt[i] + 1;
      e = {m, 8'(cnt[i]), (cnt[i] == maxc[i]), 4'(hv)};
      if (i == 0) exp_q0.push_back(e);
      else if (i == 1) exp_q1.push_back(e);
      else exp_q2.push_back(e);
    end
  endtask

  // driver
  task automatic step(input bit r, input bit c, input bit v, input bit b);
    @(negedge clock);
    #1;
    reset_n   = r;
    clear     = c;
    bit_valid = v;
    bit_in    = b;
    model_step(r, c, v, b);
  endtask

  task automatic send(input bit b);
    step(1'b1, 1'b0, 1'b1, b);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic check(input string name, input int inst, input logic [7:0] act,
                       input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst=%0d cycle=%0d actual=%0h expected=%0h", name, inst, cycle, act, exp);
    end
  endtask

  // monitor: outputs are registered, so every edge presents a result
  always @(negedge clock) begin
    logic [W-1:0] e;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      check("match", 0, {7'd0, match_0}, {7'd0, e[13]});
      check("match_count", 0, count_0, e[12:5]);
      check("count_sat", 0, {7'd0, sat_0}, {7'd0, e[4]});
      check("history", 0, {4'd0, hist_0}, {4'd0, e[3:0]});
    end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      check("match", 1, {7'd0, match_1}, {7'd0, e[13]});
      check("match_count", 1, count_1, e[12:5]);
      check("count_sat", 1, {7'd0, sat_1}, {7'd0, e[4]});
      check("history", 1, {4'd0, hist_1}, {4'd0, e[3:0]});
    end
    if (exp_q2.size() > 0) begin
      e = exp_q2.pop_front();
      check("match", 2, {7'd0, match_2}, {7'd0, e[13]});
      check("match_count", 2, {6'd0, count_2}, e[12:5]);
      check("count_sat", 2, {7'd0, sat_2}, {7'd0, e[4]});
      check("history", 2, {4'd0, hist_2}, {4'd0, e[3:0]});
    end
  end

  initial begin
    int mode;
    bit r, c, v, b;
    n_cmp   = 0;
    n_bad   = 0;
    cycle   = 0;
    pat     = '{11, 0, 15};
    maxc    = '{255, 255, 3};

    // reset state, with valid bits that must be ignored
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);

    // 1011011: two overlapping matches
    send(1); send(0); send(1); send(1); send(0); send(1); send(1);

    // gap of three idle cycles between bits 2 and 3
    step(1'b1, 1'b1, 1'b0, 1'b0);
    send(1); send(0); idle(); idle(); idle(); send(1); send(1);

    // all-zero pattern behind the fill guard
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) send(0);

    // counter saturation on the narrow instance
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send(1);

    // clear with a valid bit in the same cycle, then reset mid-stream
    step(1'b1, 1'b1, 1'b0, 1'b0);
    send(1); send(0); send(1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    send(0); send(1); send(1);
    send(1); send(0); send(1); send(1);
    send(1); send(0); send(1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    send(0); send(1); send(1);
    send(1); send(0); send(1); send(1);

    // drive the default counter into saturation with the repeating 011 tail
    step(1'b1, 1'b1, 1'b0, 1'b0);
    send(1);
    for (int i = 0; i < 260; i++) begin
      send(0); send(1); send(1);
    end
    idle();

    // randomized traffic with biased bit streams and rare clear/reset
    for (int i = 0; i < 1500; i++) begin
      mode = (i / 100) % 3;
      r = ($urandom_range(0, 127) != 0);
      c = ($urandom_range(0, 63) == 0);
      v = ($urandom_range(0, 3) != 0);
      if (mode == 0) b = 1'($urandom_range(0, 1));
      else if (mode == 1) b = ($urandom_range(0, 7) != 0);
      else b = ($urandom_range(0, 7) == 0);
      step(r, c, v, b);
    end

    @(negedge clock);
    #2;
    n_cmp++;
    if ((exp_q0.size() + exp_q1.size() + exp_q2.size()) != 0) begin
      n_bad++;
      $display("FAIL drain actual=%0d expected=0", exp_q0.size() + exp_q1.size() + exp_q2.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_serial_pattern_detector
